// File: rtl/mul_pipe_if.sv
// Request/response handshake bundle for the mul_pipe multiplier.
// slave is the multiplier side, master the requester/consumer side.
interface mul_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/mul_pipe.sv
// Two-stage radix-4 Booth multiplier (MUL/MULH/MULHU/MULHSU) with valid/ready flow control.
// Define MUL_FLUSH_EN to add a flush input that drops all in-flight ops.
module mul_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 5
) (
    input logic        clk,
    input logic        resetn,
`ifdef MUL_FLUSH_EN
    input logic        flush,
`endif
    mul_pipe_if.slave  bus
);
    localparam int unsigned XW   = WIDTH + 2;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned ROWS = XW / 2;

    logic flush_c;
`ifdef MUL_FLUSH_EN
    assign flush_c = flush;
`else
    assign flush_c = 1'b0;
`endif

    logic             s1_valid, s2_valid;
    logic [PW-1:0]    s1_sum, s1_carry;
    logic             s1_hi;
    logic [TAG_W-1:0] s1_tag, s2_tag;
    logic [WIDTH-1:0] s2_result;
    logic             s1_adv, s2_adv, accept;

    always_comb begin
        s2_adv         = !s2_valid || bus.out_ready;
        s1_adv         = !s1_valid || s2_adv;
        // resetn gating keeps in_ready low while reset is held
        bus.in_ready   = s1_adv && resetn && !flush_c;
        bus.out_valid  = s2_valid && !flush_c;
        bus.out_result = s2_result;
        bus.out_tag    = s2_tag;
        accept         = bus.in_valid && bus.in_ready;
    end

    // Operand extension: MULH treats both signed, MULHSU only a, others unsigned.
    logic          a_sgn, b_sgn;
    logic [XW-1:0] a_x, b_x;
    logic [PW-1:0] a_w;
    logic [XW:0]   b_pad;

    assign a_sgn = (bus.in_op == 2'b01) || (bus.in_op == 2'b11);
    assign b_sgn = (bus.in_op == 2'b01);
    assign a_x   = {{2{a_sgn & bus.in_a[WIDTH-1]}}, bus.in_a};
    assign b_x   = {{2{b_sgn & bus.in_b[WIDTH-1]}}, bus.in_b};
    assign a_w   = {{(PW-XW){a_x[XW-1]}}, a_x};
    assign b_pad = {b_x, 1'b0};

    logic [PW-1:0] pp [ROWS];

    for (genvar g = 0; g < ROWS; g++) begin : g_booth
        logic [2:0]    trip;
        logic [PW-1:0] mult;

        assign trip = b_pad[2*g+2 : 2*g];

        always_comb begin
            mult = '0;
            case (trip)
                3'b001, 3'b010: mult = a_w;
                3'b011:         mult = a_w << 1;
                3'b100:         mult = -(a_w << 1);
                3'b101, 3'b110: mult = -a_w;
                default:        mult = '0;
            endcase
        end

        assign pp[g] = mult << (2 * g);
    end

    // Carry-save reduction of the partial products down to a sum/carry pair.
    logic [PW-1:0] cs_s [ROWS-1];
    logic [PW-1:0] cs_c [ROWS-1];

    assign cs_s[0] = pp[0];
    assign cs_c[0] = pp[1];

    for (genvar g = 1; g < ROWS - 1; g++) begin : g_csa
        assign cs_s[g] = cs_s[g-1] ^ cs_c[g-1] ^ pp[g+1];
        assign cs_c[g] = ((cs_s[g-1] & cs_c[g-1]) | (cs_s[g-1] & pp[g+1]) |
                          (cs_c[g-1] & pp[g+1])) << 1;
    end

    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] result_d;

    assign prod     = s1_sum + s1_carry;
    assign result_d = s1_hi ? prod[PW-1:WIDTH] : prod[WIDTH-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_sum    <= '0;
            s1_carry  <= '0;
            s1_hi     <= 1'b0;
            s1_tag    <= '0;
            s2_result <= '0;
            s2_tag    <= '0;
        end else begin
            if (flush_c) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (s2_adv) s2_valid <= s1_valid;
                if (s1_adv) s1_valid <= accept;
            end
            if (accept) begin
                s1_sum   <= cs_s[ROWS-2];
                s1_carry <= cs_c[ROWS-2];
                s1_hi    <= (bus.in_op != 2'b00);
                s1_tag   <= bus.in_tag;
            end
            if (s2_adv && s1_valid) begin
                s2_result <= result_d;
                s2_tag    <= s1_tag;
            end
        end
    end
endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: directed corner cases plus randomized traffic
// scored against a plain-arithmetic product model.
module tb_mul_pipe;
    localparam int unsigned W  = 32;
    localparam int unsigned TW = 5;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mul_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

`ifdef MUL_FLUSH_EN
    logic flush;
    mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .flush  (flush),
        .bus    (bus)
    );
`else
    mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_acc    = 0;
    logic [36:0] exp_q[$];
    int          out_cycs[$];
    logic        use_dir;
    logic [31:0] dir_val;

    // Full product of the extended operands, truncated to 66 bits.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [65:0] x, y, p;
        logic        sa, sb;
        sa = (op == 2'b01) || (op == 2'b11);
        sb = (op == 2'b01);
        x  = {{34{sa & a[31]}}, a};
        y  = {{34{sb & b[31]}}, b};
        p  = x * y;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag);
        bus.in_valid = v;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_tag   = tag;
    endtask

    // Score the handshakes of the current cycle, then advance one clock.
    task automatic tick();
        logic [36:0] e;
        #1;
        if (bus.out_valid && bus.out_ready) begin
            out_cycs.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("spurious_out", {63'd0, bus.out_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("result", {32'd0, bus.out_result}, {32'd0, e[31:0]});
                check("tag", {59'd0, bus.out_tag}, {59'd0, e[36:32]});
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            n_acc++;
            exp_q.push_back({bus.in_tag,
                             use_dir ? dir_val : ref_mul(bus.in_op, bus.in_a, bus.in_b)});
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sign_exp[4];
        logic [31:0] held_r;
        logic [4:0]  held_t;
        int          acc0;

        sign_exp = '{32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        resetn        = 1'b0;
        use_dir       = 1'b0;
        dir_val       = '0;
        bus.out_ready = 1'b0;
`ifdef MUL_FLUSH_EN
        flush = 1'b0;
`endif
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_tag", bus.out_tag, 0);
        resetn = 1'b1;
        #1;
        check("in_ready_after_reset", bus.in_ready, 1);

        // Sign handling with all-ones operands
        bus.out_ready = 1'b1;
        use_dir       = 1'b1;
        for (int k = 0; k < 4; k++) begin
            dir_val = sign_exp[k];
            drive(1'b1, 2'(k), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'(k + 1));
            tick();
        end
        use_dir = 1'b0;
        drain();

        // Corner value and two-edge latency
        use_dir = 1'b1;
        dir_val = 32'h4000_0000;
        drive(1'b1, 2'b01, 32'h8000_0000, 32'h8000_0000, 5'h15);
        tick();
        use_dir = 1'b0;
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        #1;
        check("lat_not_yet", bus.out_valid, 0);
        tick();
        check("lat_valid", bus.out_valid, 1);
        check("lat_result", bus.out_result, 32'h4000_0000);
        check("lat_tag", bus.out_tag, 5'h15);
        drain();

        // Back-to-back throughput
        out_cycs.delete();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'($urandom), rand_operand(), rand_operand(), 5'(i));
            #1;
            check("tput_in_ready", bus.in_ready, 1);
            tick();
        end
        drain();
        check("tput_count", out_cycs.size(), 8);
        if (out_cycs.size() >= 8) check("tput_consecutive", out_cycs[7] - out_cycs[0], 7);

        // Backpressure
        acc0          = n_acc;
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b00, $urandom, $urandom, 5'd1);
        tick();
        drive(1'b1, 2'b11, $urandom, $urandom, 5'd2);
        tick();
        drive(1'b1, 2'b10, $urandom, $urandom, 5'd3);
        #1;
        check("bp_in_ready_low", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        held_r = bus.out_result;
        held_t = bus.out_tag;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("bp_in_ready_held", bus.in_ready, 0);
            check("bp_result_stable", bus.out_result, held_r);
            check("bp_tag_stable", bus.out_tag, held_t);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_release", bus.in_ready, 1);
        tick();
        drain();
        check("bp_accepted", n_acc - acc0, 3);

        // Reset mid-operation
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b01, $urandom, $urandom, 5'd7);
        tick();
        drive(1'b1, 2'b00, $urandom, $urandom, 5'd8);
        tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("midrst_release_ready", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_no_stale", bus.out_valid, 0);
        end

`ifdef MUL_FLUSH_EN
        // Flush drops both in-flight ops
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b10, $urandom, $urandom, 5'd9);
        tick();
        drive(1'b1, 2'b11, $urandom, $urandom, 5'd10);
        tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 5'd0);
        flush = 1'b1;
        #1;
        check("flush_in_ready", bus.in_ready, 0);
        check("flush_out_valid", bus.out_valid, 0);
        tick();
        flush = 1'b0;
        exp_q.delete();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_result", bus.out_valid, 0);
        end
        drive(1'b1, 2'b01, rand_operand(), rand_operand(), 5'd11);
        tick();
        drain();
`endif

        // Randomized traffic with random backpressure
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), rand_operand(), rand_operand(),
                  5'($urandom));
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mul_pipe.md
MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 Parameters SHALL be, one per line:
- WIDTH, 32, operand width; even, >= 8.
- TAG_W, 5, width of the pass-through tag (writeback destination).

REQ-002 Ports SHALL be, one per line:
- clk  in  1  single clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid and in_ready are both high at a rising edge.
- in_op  in  2  00 MUL low, 01 MULH signed x signed high, 10 MULHU unsigned x unsigned high, 11 MULHSU signed a x unsigned b high.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  selected product half.
- out_tag  out  TAG_W  tag of the result.
- flush  in  1  present only under MUL_FLUSH_EN.

Function
REQ-003 Each operand SHALL be extended to WIDTH+2 bits: sign-extended when treated as signed, zero-extended otherwise.
REQ-004 The product SHALL be formed with radix-4 Booth partial products (WIDTH/2+1 rows) reduced by a carry-save tree, then a final carry-propagate add. Only the low 2*WIDTH bits are used.
REQ-005 out_result SHALL be product[WIDTH-1:0] for MUL and product[2*WIDTH-1:WIDTH] otherwise; it SHALL be bit-exact to the mathematical product for every input.
REQ-006 The pipeline SHALL have two register stages:
- S1 holds Booth plus the first tree layers.
- S2 holds the final sum and drives out_*.
REQ-007 An op accepted at edge t SHALL be in S1 after t and in S2 after t+1, so out_valid is high in the cycle after edge t+1 when there is no stall.
REQ-008 Sustained throughput SHALL be one op per cycle.
REQ-009 Ready logic SHALL be:
- s2_adv = !s2_valid | out_ready
- s1_adv = !s1_valid | s2_adv
- in_ready = s1_adv
REQ-010 While out_valid=1 and out_ready=0, out_result and out_tag SHALL be held stable and S1 SHALL hold its contents.
REQ-011 With both stages full and out_ready=0, in_ready SHALL be 0. At most two ops are in flight.
REQ-012 Simultaneous output drain and input accept in one cycle SHALL lose no op and duplicate no op.
REQ-013 in_tag SHALL travel with its op and appear unchanged on out_tag.
REQ-014 Ops SHALL complete in acceptance order.

Reset
REQ-015 While resetn=0:
- s1_valid, s2_valid and out_valid SHALL be 0 immediately (asynchronously).
- out_result and out_tag SHALL be 0.
- in_ready SHALL be 0.
REQ-016 In the first cycle after resetn deasserts, in_ready SHALL be 1.
REQ-017 Reset asserted mid-operation SHALL discard all in-flight ops; no result for them appears after reset.

Configuration
REQ-018 Macro MUL_FLUSH_EN:
- Defined: the flush port exists. In a cycle with flush=1, in_ready=0 and out_valid=0. At the next edge s1_valid and s2_valid clear; data registers may keep stale values.
- Not defined: no flush port, and behaviour is exactly REQ-003..017.

Verification (WIDTH=32)
REQ-019 Directed scenarios the bench SHALL cover:
- Sign handling, a=b=0xFFFFFFFF: MUL -> 0x00000001; MULH -> 0x00000000; MULHU -> 0xFFFFFFFE; MULHSU -> 0xFFFFFFFF.
- Corner and latency: MULH a=b=0x80000000 -> 0x40000000; accept at edge t, out_valid in the cycle after edge t+1, tag preserved.
- Back-to-back throughput: 8 ops on consecutive cycles with out_ready=1 -> 8 results on 8 consecutive cycles, in order, in_ready constantly 1.
- Backpressure: out_ready=0 while issuing 3 ops -> first 2 accepted, in_ready=0 for the third, out_result stable. Raise out_ready -> all 3 delivered in order.
- Reset mid-operation: 2 ops in flight, drop resetn between edges -> out_valid=0 at once; after release, no stale result and in_ready=1.
- Flush (MUL_FLUSH_EN): 2 ops in flight, flush=1 for one cycle -> no result for either; the next op accepted afterwards returns the correct product.
